// File: rtl/ifetch_queue.sv
// Fetch stage: issues PCs to instruction memory and pairs in-order responses
// with their PCs in a small queue for decode; a redirect flush drops outstanding fetches.
module ifetch_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    input  logic            pc_valid,
    output logic            pc_ready,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            flush,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr,
    input  logic            id_ready
);
    localparam int          PW      = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [XLEN-1:0]  pc_q    [DEPTH];
    logic [XLEN-1:0]  instr_q [DEPTH];
    logic [DEPTH-1:0] filled_q, filled_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    fill_ptr_q, fill_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    drop_cnt_q, drop_cnt_d;

    logic [CW-1:0]    filled_cnt;
    logic [CW-1:0]    unfilled;
    logic [CW:0]      occupancy;
    logic             can_issue;
    logic             issue;
    logic             dequeue;
    logic             resp_drop;
    logic             resp_fill;

    // filled_q is cleared on dequeue, so its popcount is exactly the filled allocated entries
    always_comb begin
        filled_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            filled_cnt = filled_cnt + CW'(filled_q[i]);
        end
    end

    assign unfilled       = count_q - filled_cnt;
    assign occupancy      = {1'b0, count_q} + {1'b0, drop_cnt_q};
    assign can_issue      = !flush && (occupancy < DEPTH_W);

    assign imem_req_valid = pc_valid && can_issue;
    assign imem_req_addr  = pc_in;
    assign pc_ready       = imem_req_ready && can_issue;
    assign issue          = pc_valid && pc_ready;

    assign id_valid       = filled_q[rd_ptr_q] && (count_q != '0) && !flush;
    assign id_pc          = pc_q[rd_ptr_q];
    assign id_instr       = instr_q[rd_ptr_q];
    assign dequeue        = id_valid && id_ready;

    assign resp_drop      = imem_resp_valid && (drop_cnt_q != '0);
    assign resp_fill      = imem_resp_valid && (drop_cnt_q == '0) && (unfilled != '0) && !flush;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        fill_ptr_d = fill_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;
        filled_d   = filled_q;

        if (flush) begin
            wr_ptr_d   = '0;
            fill_ptr_d = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            filled_d   = '0;
            // a response landing in the flush cycle pays off one owed drop
            drop_cnt_d = drop_cnt_q + unfilled;
            if (imem_resp_valid && (drop_cnt_d != '0)) begin
                drop_cnt_d = drop_cnt_d - CW'(1);
            end
        end else begin
            if (issue) begin
                filled_d[wr_ptr_q] = 1'b0;
                wr_ptr_d           = wr_ptr_q + PW'(1);
            end
            if (resp_drop) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            if (resp_fill) begin
                filled_d[fill_ptr_q] = 1'b1;
                fill_ptr_d           = fill_ptr_q + PW'(1);
            end
            if (dequeue) begin
                filled_d[rd_ptr_q] = 1'b0;
                rd_ptr_d           = rd_ptr_q + PW'(1);
            end
            case ({issue, dequeue})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            fill_ptr_q <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
            filled_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            fill_ptr_q <= fill_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
            filled_q   <= filled_d;
            if (issue) begin
                pc_q[wr_ptr_q] <= pc_in;
            end
            if (resp_fill) begin
                instr_q[fill_ptr_q] <= imem_resp_data;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed vector table, hand-written latency sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_ifetch_queue;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] pc_in;
    logic            pc_valid;
    logic            pc_ready;
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            flush;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_instr;
    logic            id_ready;

    always #5 clk = ~clk;

    ifetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc_in           (pc_in),
        .pc_valid        (pc_valid),
        .pc_ready        (pc_ready),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .flush           (flush),
        .id_valid        (id_valid),
        .id_pc           (id_pc),
        .id_instr        (id_instr),
        .id_ready        (id_ready)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        bit          filled;
    } ent_t;
    ent_t mq[$];
    int   m_drop = 0;
    bit   e_prdy, e_rqv, e_idv;
    logic [31:0] e_pc, e_ins;

    typedef struct {
        logic [31:0] pc;
        int          due;
    } mreq_t;
    mreq_t mem[$];
    bit    mem_on   = 0;
    int    cyc      = 0;
    int    last_due = 0;

    typedef struct {
        bit          rst_n, pv;
        logic [31:0] pc;
        bit          rr, rv;
        logic [31:0] rd;
        bit          fl, idr;
        bit          e_prdy, e_rqv, e_idv, chkd;
        logic [31:0] e_pc, e_ins;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [31:0] I(input logic [31:0] p);
        return p ^ 32'hA5A5_0000;
    endfunction

    function automatic vec_t mk(input bit rst_n, input bit pv, input logic [31:0] pc,
                                input bit rr, input bit rv, input logic [31:0] rd,
                                input bit fl, input bit idr, input bit ep, input bit eq,
                                input bit ei, input bit cd, input logic [31:0] epc,
                                input logic [31:0] eins);
        vec_t v;
        v.rst_n = rst_n; v.pv = pv; v.pc = pc; v.rr = rr; v.rv = rv; v.rd = rd;
        v.fl = fl; v.idr = idr; v.e_prdy = ep; v.e_rqv = eq; v.e_idv = ei;
        v.chkd = cd; v.e_pc = epc; v.e_ins = eins;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // expected outputs from the abstract queue state and the current inputs
    function automatic void model_eval();
        bit ci;
        ci     = !flush && ((mq.size() + m_drop) < DEPTH);
        e_prdy = imem_req_ready && ci;
        e_rqv  = pc_valid && ci;
        e_idv  = !flush && (mq.size() > 0) && mq[0].filled;
        e_pc   = e_idv ? mq[0].pc  : 32'h0;
        e_ins  = e_idv ? mq[0].ins : 32'h0;
    endfunction

    task automatic model_check();
        model_eval();
        chk("m_pc_ready", pc_ready, e_prdy);
        chk("m_req_valid", imem_req_valid, e_rqv);
        chk("m_req_addr", imem_req_addr, pc_in);
        chk("m_id_valid", id_valid, e_idv);
        if (e_idv) begin
            chk("m_id_pc", id_pc, e_pc);
            chk("m_id_instr", id_instr, e_ins);
        end
    endtask

    function automatic void model_update();
        if (!rst) begin
            mq.delete();
            m_drop = 0;
            return;
        end
        if (flush) begin
            int unf = 0;
            foreach (mq[i]) if (!mq[i].filled) unf++;
            m_drop += unf;
            if (imem_resp_valid && m_drop > 0) m_drop--;
            mq.delete();
            return;
        end
        if (imem_resp_valid) begin
            if (m_drop > 0) m_drop--;
            else begin
                for (int i = 0; i < mq.size(); i++) begin
                    if (!mq[i].filled) begin
                        mq[i].ins    = imem_resp_data;
                        mq[i].filled = 1;
                        break;
                    end
                end
            end
        end
        if (e_idv && id_ready) void'(mq.pop_front());
        if (pc_valid && e_prdy) mq.push_back('{pc: pc_in, ins: 32'h0, filled: 1'b0});
    endfunction

    function automatic void mem_update();
        mreq_t r;
        int    lat;
        if (imem_resp_valid && mem.size() > 0) void'(mem.pop_front());
        if (e_rqv && imem_req_ready) begin
            lat      = int'($urandom_range(1, 4));
            r.pc     = pc_in;
            r.due    = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            last_due = r.due;
            mem.push_back(r);
        end
    endfunction

    task automatic cycle_end();
        model_eval();
        @(posedge clk);
        model_update();
        if (mem_on) mem_update();
        cyc++;
        #1;
    endtask

    task automatic drive(input bit rst_n, input bit pv, input logic [31:0] pc, input bit rr,
                         input bit rv, input logic [31:0] rd, input bit fl, input bit idr);
        rst = rst_n; pc_valid = pv; pc_in = pc; imem_req_ready = rr;
        imem_resp_valid = rv; imem_resp_data = rd; flush = fl; id_ready = idr;
    endtask

    task automatic apply(input vec_t v, input int idx);
        drive(v.rst_n, v.pv, v.pc, v.rr, v.rv, v.rd, v.fl, v.idr);
        #1;
        chk($sformatf("v%0d pc_ready", idx), pc_ready, v.e_prdy);
        chk($sformatf("v%0d req_valid", idx), imem_req_valid, v.e_rqv);
        chk($sformatf("v%0d id_valid", idx), id_valid, v.e_idv);
        if (v.e_idv || v.chkd) begin
            chk($sformatf("v%0d id_pc", idx), id_pc, v.e_pc);
            chk($sformatf("v%0d id_instr", idx), id_instr, v.e_ins);
        end
        model_check();
        cycle_end();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // backpressure until full, then drain
        tbl.push_back(mk(1,1,32'h40,1,0,0,0,0, 1,1,0,1,32'h0,32'h0));
        tbl.push_back(mk(1,1,32'h44,1,1,I(32'h40),0,0, 1,1,0,0,0,0));
        tbl.push_back(mk(1,1,32'h48,1,1,I(32'h44),0,0, 1,1,1,0,32'h40,I(32'h40)));
        tbl.push_back(mk(1,1,32'h4C,1,1,I(32'h48),0,0, 1,1,1,0,32'h40,I(32'h40)));
        tbl.push_back(mk(1,1,32'h50,1,1,I(32'h4C),0,0, 0,0,1,0,32'h40,I(32'h40)));
        tbl.push_back(mk(1,1,32'h50,1,0,0,0,1, 0,0,1,0,32'h40,I(32'h40)));
        tbl.push_back(mk(1,1,32'h50,1,0,0,0,1, 1,1,1,0,32'h44,I(32'h44)));
        tbl.push_back(mk(1,0,32'h0,1,1,I(32'h50),0,1, 1,0,1,0,32'h48,I(32'h48)));
        tbl.push_back(mk(1,0,32'h0,1,0,0,0,1, 1,0,1,0,32'h4C,I(32'h4C)));
        tbl.push_back(mk(1,0,32'h0,1,0,0,0,1, 1,0,1,0,32'h50,I(32'h50)));
        tbl.push_back(mk(1,0,32'h0,1,0,0,0,1, 1,0,0,0,0,0));
        // flush with two requests in flight
        tbl.push_back(mk(1,1,32'h20,1,0,0,0,1, 1,1,0,0,0,0));
        tbl.push_back(mk(1,1,32'h24,1,0,0,0,1, 1,1,0,0,0,0));
        tbl.push_back(mk(1,1,32'h28,1,0,0,1,1, 0,0,0,0,0,0));
        tbl.push_back(mk(1,1,32'h100,1,1,I(32'h20),0,1, 1,1,0,0,0,0));
        tbl.push_back(mk(1,0,32'h0,1,1,I(32'h24),0,1, 1,0,0,0,0,0));
        tbl.push_back(mk(1,0,32'h0,1,1,I(32'h100),0,1, 1,0,0,0,0,0));
        tbl.push_back(mk(1,0,32'h0,1,0,0,0,1, 1,0,1,0,32'h100,I(32'h100)));
        // flush coincident with a response and a dequeue attempt
        tbl.push_back(mk(1,1,32'h200,1,0,0,0,1, 1,1,0,0,0,0));
        tbl.push_back(mk(1,1,32'h204,1,0,0,0,1, 1,1,0,0,0,0));
        tbl.push_back(mk(1,1,32'h208,1,1,I(32'h200),0,1, 1,1,0,0,0,0));
        tbl.push_back(mk(1,0,32'h0,1,1,I(32'h204),1,1, 0,0,0,0,0,0));
        tbl.push_back(mk(1,1,32'h300,1,1,I(32'h208),0,1, 1,1,0,0,0,0));
        tbl.push_back(mk(1,0,32'h0,1,1,I(32'h300),0,1, 1,0,0,0,0,0));
        tbl.push_back(mk(1,0,32'h0,1,0,0,0,0, 1,0,1,0,32'h300,I(32'h300)));
        tbl.push_back(mk(1,0,32'h0,1,0,0,0,1, 1,0,1,0,32'h300,I(32'h300)));
        // reset with three entries queued, then a stray late response
        tbl.push_back(mk(1,1,32'h400,1,0,0,0,0, 1,1,0,0,0,0));
        tbl.push_back(mk(1,1,32'h404,1,1,I(32'h400),0,0, 1,1,0,0,0,0));
        tbl.push_back(mk(1,1,32'h408,1,1,I(32'h404),0,0, 1,1,1,0,32'h400,I(32'h400)));
        tbl.push_back(mk(0,0,32'h0,1,0,0,0,0, 1,0,1,0,32'h400,I(32'h400)));
        tbl.push_back(mk(1,0,32'h0,1,1,I(32'h408),0,0, 1,0,0,1,32'h0,32'h0));
        tbl.push_back(mk(1,1,32'h40C,1,0,0,0,0, 1,1,0,1,32'h0,32'h0));
        tbl.push_back(mk(1,0,32'h0,1,1,I(32'h40C),0,0, 1,0,0,0,0,0));
        tbl.push_back(mk(1,0,32'h0,1,0,0,0,1, 1,0,1,0,32'h40C,I(32'h40C)));

        drive(0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
        cycle_end();
        cycle_end();

        foreach (tbl[i]) apply(tbl[i], i);

        // steady stream: 1-cycle memory, decode always ready
        for (int k = 0; k < 15; k++) begin
            drive(1, k < 12, 32'(4 * k), 1, (k >= 1) && (k <= 12), I(32'(4 * (k - 1))), 0, 1);
            #1;
            chk($sformatf("ss%0d pc_ready", k), pc_ready, 1);
            chk($sformatf("ss%0d id_valid", k), id_valid, (k >= 2) && (k <= 13));
            if ((k >= 2) && (k <= 13)) begin
                chk($sformatf("ss%0d id_pc", k), id_pc, 32'(4 * (k - 2)));
                chk($sformatf("ss%0d id_instr", k), id_instr, I(32'(4 * (k - 2))));
            end
            model_check();
            cycle_end();
        end

        // variable latency: 0x10 returns after 3 cycles, 0x14/0x18 right behind it
        for (int k = 0; k < 8; k++) begin
            logic [31:0] exp_pc;
            bit          exp_v;
            exp_v  = (k >= 4) && (k <= 6);
            exp_pc = 32'h10 + 32'(4 * (k - 4));
            drive(1, k < 3, 32'h10 + 32'(4 * k), 1, (k >= 3) && (k <= 5),
                  I(32'h10 + 32'(4 * (k - 3))), 0, 1);
            #1;
            chk($sformatf("vl%0d id_valid", k), id_valid, exp_v);
            if (exp_v) begin
                chk($sformatf("vl%0d id_pc", k), id_pc, exp_pc);
                chk($sformatf("vl%0d id_instr", k), id_instr, I(exp_pc));
            end
            model_check();
            cycle_end();
        end

        // randomized traffic against the reference model
        drive(0, 0, 32'h0, 1, 0, 32'h0, 0, 0);
        cycle_end();
        mem.delete();
        mem_on   = 1;
        last_due = cyc;
        for (int n = 0; n < 3000; n++) begin
            bit          rv;
            logic [31:0] rd;
            rv = (mem.size() > 0) && (mem[0].due <= cyc);
            rd = rv ? I(mem[0].pc) : 32'($urandom);
            drive($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0,
                  32'($urandom) & 32'hFFFF_FFFC, $urandom_range(0, 3) != 0,
                  rv, rd, $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
            #1;
            model_check();
            cycle_end();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
Instruction-fetch stage sitting directly downstream of the PC generator. It takes each PC, issues it to instruction memory over a valid/ready request channel, and pairs in-order memory responses with their PCs in a DEPTH-entry queue. It presents {pc, instr} to decode over a valid/ready handshake. A redirect flush discards all queued and in-flight fetches.

Parameters:
XLEN, 32, address/instruction width
DEPTH, 4, queue entries, power of 2, >= 2; bounds allocated entries plus pending drops
CW, $clog2(DEPTH+1), width of the count and drop counters

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous, active-low reset
pc_in  input  XLEN  next fetch PC from the PC generator
pc_valid  input  1  pc_in valid
pc_ready  output  1  fetch accepted this cycle (pc_valid && pc_ready = issue)
imem_req_valid  output  1  memory request valid
imem_req_addr  output  XLEN  memory request address (= pc_in)
imem_req_ready  input  1  memory accepts request
imem_resp_valid  input  1  in-order response valid; no backpressure
imem_resp_data  input  XLEN  fetched instruction
flush  input  1  redirect: discard all queued and in-flight fetches
id_valid  output  1  head entry valid to decode
id_pc  output  XLEN  head entry PC
id_instr  output  XLEN  head entry instruction
id_ready  input  1  decode accepts head

Behaviour:
- State: entry arrays pc_q, instr_q, filled_q[DEPTH]; pointers wr_ptr, fill_ptr, rd_ptr; count (allocated entries, 0..DEPTH); drop_cnt (responses still owed for flushed requests).
- Credit: can_issue = !flush && (count + drop_cnt < DEPTH), using registered values only. Dequeue in the same cycle frees no credit.
- imem_req_valid = pc_valid && can_issue. imem_req_addr = pc_in. pc_ready = imem_req_ready && can_issue.
- Issue (pc_valid && pc_ready): write pc_q[wr_ptr] <= pc_in, filled_q[wr_ptr] <= 0, wr_ptr++, count++.
- Response handling:
  - If drop_cnt != 0: drop_cnt-- and discard the data.
  - Else if an unfilled entry exists: instr_q[fill_ptr] <= data, filled_q[fill_ptr] <= 1, fill_ptr++.
  - Else (stray response, e.g. after reset mid-transaction): ignore.
- Output: id_valid = filled_q[rd_ptr] && count != 0 && !flush. id_pc and id_instr come from the head entry.
- Dequeue (id_valid && id_ready): rd_ptr++, count--.
- Simultaneous issue and dequeue: count is unchanged.
- Latency:
  - A response in cycle N makes id_valid high in cycle N+1; there is no bypass.
  - With 1-cycle memory and DEPTH=4, sustained throughput is 1 instruction per cycle.
- Pointer wrap: all pointers are log2(DEPTH) bits and wrap modulo DEPTH naturally.
- Full: count + drop_cnt == DEPTH, so pc_ready=0 and imem_req_valid=0.
- Empty: id_valid=0.
- flush (highest priority):
  - The same cycle is gated: no issue, no dequeue, id_valid=0.
  - Next cycle: wr/fill/rd pointers = 0, count = 0, filled_q all 0.
  - drop_cnt <= drop_cnt + unfilled - (imem_resp_valid ? 1 : 0), where unfilled = count minus filled entries. A response arriving in the flush cycle is itself discarded.
  - Back-to-back flushes accumulate into drop_cnt correctly.
- Reset (rst==0 at posedge), at any time including mid-operation:
  - pointers, count, drop_cnt = 0; filled_q = 0; pc_q/instr_q = 0.
  - Hence id_valid=0 and id_pc=id_instr=0. imem_req_valid follows pc_valid && can_issue from the first cycle after reset.

Test Plan:
- Steady stream: PCs 0,4,8,... with 1-cycle memory returning instr=pc^32'hA5A5_0000 and id_ready=1. Expect id_valid high every cycle from cycle 2, with {id_pc,id_instr} = {0,0xA5A5_0000}, {4,0xA5A5_0004}, ... in order.
- Backpressure/full: id_ready=0 with DEPTH=4. Exactly 4 requests issue, then pc_ready=0. Release id_ready: entries drain in order and issue resumes after the first dequeue cycle.
- Variable latency: responses for PCs 0x10,0x14,0x18 delayed 3,1,1 cycles (still in order). Expect the head stays invalid until the 0x10 data arrives, then three back-to-back outputs.
- Flush with 2 in flight: issue 0x20,0x24, then flush before any response. Expect drop_cnt=2 and the next two responses discarded. The new PC 0x100, issued after the flush, appears on id_pc with its own data.
- Flush coincident with a response and a dequeue: expect no dequeue, the response discarded, id_valid=0 that cycle, and drop_cnt = unfilled-1.
- Reset mid-stream: rst=0 for 1 cycle with 3 entries queued. Expect id_valid=0 and id_pc=id_instr=0 next cycle, the stray late response ignored, and a normal restart at the next PC.
